// File: rtl/testbasic_mc_reader.sv
`default_nettype none
// ============================================================================
// Module   : testbasic_mc_reader
// Purpose  : Round-robin reader of N_CH blocking input ports (sync/notify
//            handshake). Each received value is added into a running
//            accumulator. The sum and its source channel are offered on one
//            blocking output port. An optional per-channel wait timeout
//            skips a silent producer so that it cannot stall the others.
// Ports    : clk          - clock, rising edge
//            rst          - asynchronous reset, active-low
//            b_in         - channel data, channel i at [i*W +: W]
//            b_in_sync    - producer i has valid data
//            b_in_notify  - ready to read channel i (one-hot or zero)
//            b_out        - accumulator value offered to the consumer
//            b_out_ch     - channel index of the last read
//            b_out_sync   - consumer accepts
//            b_out_notify - b_out/b_out_ch valid
//            skip_pulse   - one-cycle pulse when a channel is skipped
// Revision : 1.0 - initial release
// ============================================================================
module testbasic_mc_reader #(
    parameter int N_CH     = 4,
    parameter int W        = 32,
    parameter int INIT_VAL = 4,
    parameter int TIMEOUT  = 0,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_CH*W-1:0]   b_in,
    input  logic [N_CH-1:0]     b_in_sync,
    output logic [N_CH-1:0]     b_in_notify,
    output logic [W-1:0]        b_out,
    output logic [CH_W-1:0]     b_out_ch,
    input  logic                b_out_sync,
    output logic                b_out_notify,
    output logic                skip_pulse
);

    localparam logic [0:0]      SEC_READ   = 1'b0;
    localparam logic [0:0]      SEC_WRITE  = 1'b1;
    localparam logic [N_CH-1:0] NOTIFY_RST = N_CH'(1);
    localparam logic [CH_W-1:0] PTR_LAST   = CH_W'(N_CH - 1);
    localparam logic [31:0]     WAIT_LAST  = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);
    localparam bit              TO_EN      = (TIMEOUT != 0);

    // State and registered outputs
    logic [0:0]      section, section_nxt;
    logic [CH_W-1:0] ptr, ptr_nxt;
    logic [W-1:0]    acc, acc_nxt;
    logic [31:0]     wait_cnt, wait_nxt;
    logic [N_CH-1:0] in_notify_q, in_notify_nxt;
    logic [W-1:0]    out_q, out_nxt;
    logic [CH_W-1:0] out_ch_q, out_ch_nxt;
    logic            out_notify_q, out_notify_nxt;
    logic            skip_q, skip_nxt;

    // Selected channel and derived values
    logic [W-1:0]    sel_data;
    logic            sel_sync;
    logic [W-1:0]    sum;
    logic [CH_W-1:0] ptr_inc;

    function automatic logic [N_CH-1:0] onehot(input logic [CH_W-1:0] p);
        logic [N_CH-1:0] v;
        v = '0;
        for (int i = 0; i < N_CH; i++) begin
            v[i] = (p == CH_W'(i));
        end
        return v;
    endfunction

    // Only the pointed-to channel is looked at; stray syncs are ignored.
    always_comb begin
        sel_data = '0;
        sel_sync = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (ptr == CH_W'(i)) begin
                sel_data = b_in[i*W +: W];
                sel_sync = b_in_sync[i];
            end
        end
    end

    assign sum     = acc + sel_data;  // wraps mod 2^W
    assign ptr_inc = (ptr == PTR_LAST) ? '0 : ptr + 1'b1;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            section      <= SEC_READ;
            ptr          <= '0;
            acc          <= W'(INIT_VAL);
            wait_cnt     <= '0;
            in_notify_q  <= NOTIFY_RST;
            out_q        <= '0;
            out_ch_q     <= '0;
            out_notify_q <= 1'b0;
            skip_q       <= 1'b0;
        end else begin
            section      <= section_nxt;
            ptr          <= ptr_nxt;
            acc          <= acc_nxt;
            wait_cnt     <= wait_nxt;
            in_notify_q  <= in_notify_nxt;
            out_q        <= out_nxt;
            out_ch_q     <= out_ch_nxt;
            out_notify_q <= out_notify_nxt;
            skip_q       <= skip_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        section_nxt    = section;
        ptr_nxt        = ptr;
        acc_nxt        = acc;
        wait_nxt       = wait_cnt;
        in_notify_nxt  = in_notify_q;
        out_nxt        = out_q;
        out_ch_nxt     = out_ch_q;
        out_notify_nxt = out_notify_q;
        skip_nxt       = 1'b0;
        case (section)
            SEC_READ: begin
                if (sel_sync) begin
                    // A transfer in the timeout cycle wins over the skip.
                    acc_nxt        = sum;
                    out_nxt        = sum;
                    out_ch_nxt     = ptr;
                    in_notify_nxt  = '0;
                    out_notify_nxt = 1'b1;
                    wait_nxt       = '0;
                    section_nxt    = SEC_WRITE;
                end else if (TO_EN && (wait_cnt == WAIT_LAST)) begin
                    ptr_nxt       = ptr_inc;
                    in_notify_nxt = onehot(ptr_inc);
                    wait_nxt      = '0;
                    skip_nxt      = 1'b1;
                end else if (TO_EN) begin
                    wait_nxt = wait_cnt + 32'd1;
                end else begin
                    wait_nxt = '0;
                end
            end
            default: begin
                if (b_out_sync) begin
                    out_notify_nxt = 1'b0;
                    ptr_nxt        = ptr_inc;
                    in_notify_nxt  = onehot(ptr_inc);
                    section_nxt    = SEC_READ;
                end
            end
        endcase
    end

    // Outputs come straight from registers
    always_comb begin
        b_in_notify  = in_notify_q;
        b_out        = out_q;
        b_out_ch     = out_ch_q;
        b_out_notify = out_notify_q;
        skip_pulse   = skip_q;
    end

endmodule
`default_nettype wire
